imem_arbiter: RTL and testbench

Sequencer and arbiter for the single-port instruction memory shared by the instruction fetch stage and the program loader/debug port. It grants one memory access at a time and counts the fixed memory read latency. It returns read data to the owning requester and drives a fetch stall while fetch is waiting. A flush from the execute-stage branch redirect discards any in-flight fetch response, so a stale instruction never enters IF/ID.

---
 rtl/imem_arbiter_if.sv | 37 +++
 rtl/imem_arbiter.sv | 93 +++++++++
 tb/tb_imem_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_arbiter_if.sv
// Shared instruction-memory port bundle: fetch requester, loader/debug requester
// and the single-port memory, as seen by the arbiter (slave) and its environment (master).
interface imem_arbiter_if;
  logic        f_req;
  logic [31:0] f_addr;
  logic        flush;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        stall_f;

  logic        l_req;
  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt;
  logic        l_rvalid;
  logic [31:0] l_rdata;

  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  modport slave (
    input  f_req, f_addr, flush, l_req, l_we, l_addr, l_wdata, m_rdata,
    output f_gnt, f_rvalid, f_rdata, stall_f, l_gnt, l_rvalid, l_rdata,
           m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output f_req, f_addr, flush, l_req, l_we, l_addr, l_wdata, m_rdata,
    input  f_gnt, f_rvalid, f_rdata, stall_f, l_gnt, l_rvalid, l_rdata,
           m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port instruction memory sequencer: one access at a time, fixed read latency,
// loader-first priority with a fetch starvation cap, and flush-driven fetch response drop.
module imem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  imem_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_F, OWN_L} owner_t;

  typedef struct packed {
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_CAP = 4'(STARVE_MAX);

  state_t     state;
  owner_t     owner;
  logic [2:0] lat_cnt;
  logic       drop;
  logic [3:0] starve_cnt;

  logic     arb_slot, resp, l_win, f_win, f_resp, f_pend, f_rv, l_rv;
  mem_req_t issue;

  // Every output is qualified by rst so the port goes quiet the instant reset asserts,
  // not at the next edge.
  always_comb begin
    arb_slot = rst & ((state == IDLE) | ((state == BUSY) & (lat_cnt == 3'd0)));
    resp     = rst & (state == BUSY) & (lat_cnt == 3'd0);
    l_win    = arb_slot & bus.l_req & ~(bus.f_req & (starve_cnt == STARVE_CAP));
    f_win    = arb_slot & bus.f_req & ~l_win;
    f_resp   = resp & (owner == OWN_F);
    f_pend   = (state == BUSY) & (owner == OWN_F) & (lat_cnt != 3'd0);
    f_rv     = f_resp & ~drop & ~bus.flush;
    l_rv     = resp & (owner == OWN_L);

    issue       = '0;
    issue.en    = l_win | f_win;
    issue.we    = l_win & bus.l_we;
    issue.addr  = l_win ? bus.l_addr : (f_win ? bus.f_addr : 32'd0);
    issue.wdata = l_win ? bus.l_wdata : 32'd0;
  end

  assign bus.m_en     = issue.en;
  assign bus.m_we     = issue.we;
  assign bus.m_addr   = issue.addr;
  assign bus.m_wdata  = issue.wdata;
  assign bus.f_gnt    = f_win;
  assign bus.l_gnt    = l_win;
  assign bus.f_rvalid = f_rv;
  assign bus.l_rvalid = l_rv;
  assign bus.f_rdata  = f_rv ? bus.m_rdata : 32'd0;
  assign bus.l_rdata  = l_rv ? bus.m_rdata : 32'd0;
  assign bus.stall_f  = rst & bus.f_req & ~f_rv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_F;
      lat_cnt    <= 3'd0;
      drop       <= 1'b0;
      starve_cnt <= 4'd0;
    end else begin
      // Writes retire in their grant cycle; only reads occupy the latency window.
      if (issue.en && !issue.we) begin
        state   <= BUSY;
        lat_cnt <= LAT_INIT;
        owner   <= f_win ? OWN_F : OWN_L;
      end else if (state == BUSY) begin
        if (lat_cnt == 3'd0) state <= IDLE;
        else                 lat_cnt <= lat_cnt - 3'd1;
      end

      // A fetch issued alongside a flush is on the wrong path, so it is dropped too.
      if (bus.flush && (f_win || f_pend)) drop <= 1'b1;
      else if (f_resp)                    drop <= 1'b0;

      if (!bus.f_req || f_win)                   starve_cnt <= 4'd0;
      else if (l_win && starve_cnt != STARVE_CAP) starve_cnt <= starve_cnt + 4'd1;
    end
  end

  a_one_grant: assert property (@(posedge clk) disable iff (!rst) !(f_win && l_win));

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: a MEM_LAT=1 instance for streaming fetch and a
// MEM_LAT=3 / STARVE_MAX=4 instance for loader, starvation, flush and reset scenarios.
module tb_imem_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  imem_arbiter_if b1();
  imem_arbiter_if b3();

  imem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) d1 (.clk(clk), .rst(rst), .bus(b1));
  imem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) d3 (.clk(clk), .rst(rst), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: word i holds 0x1000_0000 + 4*i until the loader overwrites it.
  logic [31:0] mem [0:63];
  logic [31:0] p1;
  logic [31:0] p3 [0:2];

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i * 4);
    end else if (b3.m_en && b3.m_we) begin
      mem[b3.m_addr[7:2]] <= b3.m_wdata;
    end
    p1    <= mem[b1.m_addr[7:2]];
    p3[0] <= mem[b3.m_addr[7:2]];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign b1.m_rdata = p1;
  assign b3.m_rdata = p3[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    tick();
    b3.f_req = 1'b0; b3.l_req = 1'b0; b3.flush = 1'b0; b3.l_we = 1'b0;
    b1.f_req = 1'b0; b1.flush = 1'b0;
    repeat (4) tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    b3.f_req = 1'b1; b3.f_addr = 32'h40; b3.l_req = 1'b1; b3.l_we = 1'b1;
    b3.l_addr = 32'h50; b3.l_wdata = 32'h1234; b1.f_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (b3.m_en !== 1'b0) begin bad++; $display("FAIL rst_m_en got %b want 0", b3.m_en); end
    total++; if (b3.f_gnt !== 1'b0 || b3.l_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got f=%b l=%b want 0", b3.f_gnt, b3.l_gnt); end
    total++; if (b3.stall_f !== 1'b0) begin bad++; $display("FAIL rst_stall got %b want 0", b3.stall_f); end
    total++; if (b3.m_addr !== 32'd0 || b3.m_wdata !== 32'd0 || b3.m_we !== 1'b0) begin bad++; $display("FAIL rst_bus got a=%h d=%h we=%b want 0", b3.m_addr, b3.m_wdata, b3.m_we); end
    total++; if (b1.f_gnt !== 1'b0 || b1.stall_f !== 1'b0) begin bad++; $display("FAIL rst_d1 got g=%b s=%b want 0", b1.f_gnt, b1.stall_f); end
    total++; if (d3.lat_cnt !== 3'd0 || d3.drop !== 1'b0 || d3.starve_cnt !== 4'd0 || d3.state !== 1'b0) begin bad++; $display("FAIL rst_regs got lat=%0d drop=%b starve=%0d st=%b want 0", d3.lat_cnt, d3.drop, d3.starve_cnt, d3.state); end
    b3.l_req = 1'b0; b3.l_we = 1'b0; b1.f_req = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    total++; if (b3.f_gnt !== 1'b1 || b3.m_addr !== 32'h40 || b3.stall_f !== 1'b1) begin bad++; $display("FAIL first_fetch got g=%b a=%h s=%b want 1 40 1", b3.f_gnt, b3.m_addr, b3.stall_f); end
    repeat (3) tick();
    b3.f_req = 1'b0;
    @(negedge clk);
    total++; if (b3.f_rvalid !== 1'b1 || b3.f_rdata !== 32'h1000_0040) begin bad++; $display("FAIL first_fetch_rsp got v=%b d=%h want 1 10000040", b3.f_rvalid, b3.f_rdata); end
    drain();
  endtask

  task automatic test_fetch_seq();
    for (int i = 0; i < 5; i++) begin
      logic        eg, ev, es;
      logic [31:0] ed;
      tick();
      b1.f_req  = (i < 3);
      b1.f_addr = 32'(i * 4);
      @(negedge clk);
      eg = (i < 3);
      ev = (i >= 1 && i <= 3);
      ed = ev ? 32'h1000_0000 + 32'((i - 1) * 4) : 32'd0;
      es = (i == 0);
      total++; if (b1.f_gnt !== eg) begin bad++; $display("FAIL seq_gnt[%0d] got %b want %b", i, b1.f_gnt, eg); end
      total++; if (b1.f_rvalid !== ev || b1.f_rdata !== ed) begin bad++; $display("FAIL seq_rsp[%0d] got v=%b d=%h want v=%b d=%h", i, b1.f_rvalid, b1.f_rdata, ev, ed); end
      total++; if (b1.stall_f !== es) begin bad++; $display("FAIL seq_stall[%0d] got %b want %b", i, b1.stall_f, es); end
      if (eg) begin
        total++; if (b1.m_addr !== 32'(i * 4) || b1.m_we !== 1'b0) begin bad++; $display("FAIL seq_addr[%0d] got %h we=%b want %h", i, b1.m_addr, b1.m_we, i * 4); end
      end
    end
    drain();
  endtask

  task automatic test_write_then_fetch();
    tick();
    b3.l_req = 1'b1; b3.l_we = 1'b1; b3.l_addr = 32'h10; b3.l_wdata = 32'hDEAD_BEEF;
    b3.f_req = 1'b1; b3.f_addr = 32'h10;
    @(negedge clk);
    total++; if (b3.l_gnt !== 1'b1 || b3.f_gnt !== 1'b0 || b3.m_we !== 1'b1) begin bad++; $display("FAIL wr_gnt got l=%b f=%b we=%b want 1 0 1", b3.l_gnt, b3.f_gnt, b3.m_we); end
    total++; if (b3.m_addr !== 32'h10 || b3.m_wdata !== 32'hDEAD_BEEF || b3.stall_f !== 1'b1) begin bad++; $display("FAIL wr_bus got a=%h d=%h s=%b", b3.m_addr, b3.m_wdata, b3.stall_f); end
    tick();
    b3.l_req = 1'b0; b3.l_we = 1'b0;
    @(negedge clk);
    total++; if (b3.f_gnt !== 1'b1 || b3.m_we !== 1'b0 || b3.m_addr !== 32'h10 || b3.l_rvalid !== 1'b0) begin bad++; $display("FAIL wr_fetch_gnt got g=%b we=%b a=%h lrv=%b", b3.f_gnt, b3.m_we, b3.m_addr, b3.l_rvalid); end
    repeat (3) tick();
    b3.f_req = 1'b0;
    @(negedge clk);
    total++; if (b3.f_rvalid !== 1'b1 || b3.f_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_fetch_rsp got v=%b d=%h want 1 deadbeef", b3.f_rvalid, b3.f_rdata); end
    drain();
  endtask

  task automatic test_starvation();
    for (int c = 0; c < 16; c++) begin
      logic el, ef, elv, efv;
      tick();
      b3.l_req = 1'b1; b3.l_we = 1'b0; b3.l_addr = 32'h80;
      b3.f_req = (c < 15); b3.f_addr = 32'h84;
      @(negedge clk);
      el  = (c % 3 == 0) && (c != 12);
      ef  = (c == 12);
      elv = (c == 3 || c == 6 || c == 9 || c == 12);
      efv = (c == 15);
      total++; if (b3.l_gnt !== el || b3.f_gnt !== ef) begin bad++; $display("FAIL starve_gnt[%0d] got l=%b f=%b want l=%b f=%b", c, b3.l_gnt, b3.f_gnt, el, ef); end
      if (elv) begin
        total++; if (b3.l_rvalid !== 1'b1 || b3.l_rdata !== 32'h1000_0080) begin bad++; $display("FAIL starve_lrsp[%0d] got v=%b d=%h", c, b3.l_rvalid, b3.l_rdata); end
      end
      if (efv) begin
        total++; if (b3.f_rvalid !== 1'b1 || b3.f_rdata !== 32'h1000_0084) begin bad++; $display("FAIL starve_frsp got v=%b d=%h", b3.f_rvalid, b3.f_rdata); end
      end
      if (c == 12) begin
        total++; if (d3.starve_cnt !== 4'd4) begin bad++; $display("FAIL starve_cap got %0d want 4", d3.starve_cnt); end
      end
      if (c == 13) begin
        total++; if (d3.starve_cnt !== 4'd0) begin bad++; $display("FAIL starve_clr got %0d want 0", d3.starve_cnt); end
      end
    end
    drain();
  endtask

  task automatic test_flush_drop();
    tick();
    b3.f_req = 1'b1; b3.f_addr = 32'h20;
    @(negedge clk);
    total++; if (b3.f_gnt !== 1'b1) begin bad++; $display("FAIL fl_gnt got %b want 1", b3.f_gnt); end
    for (int c = 1; c < 7; c++) begin
      tick();
      b3.flush = (c == 1);
      if (c >= 2) b3.f_addr = 32'h30;
      if (c == 6) b3.f_req = 1'b0;
      @(negedge clk);
      if (c < 6) begin
        total++; if (b3.stall_f !== 1'b1 || b3.f_rvalid !== 1'b0) begin bad++; $display("FAIL fl_stall[%0d] got s=%b v=%b want 1 0", c, b3.stall_f, b3.f_rvalid); end
      end
      if (c == 3) begin
        total++; if (b3.f_gnt !== 1'b1 || b3.m_addr !== 32'h30 || b3.f_rdata !== 32'd0) begin bad++; $display("FAIL fl_regnt got g=%b a=%h d=%h", b3.f_gnt, b3.m_addr, b3.f_rdata); end
      end
      if (c == 4) begin
        total++; if (d3.drop !== 1'b0) begin bad++; $display("FAIL fl_drop_clr got %b want 0", d3.drop); end
      end
      if (c == 6) begin
        total++; if (b3.f_rvalid !== 1'b1 || b3.f_rdata !== 32'h1000_0030) begin bad++; $display("FAIL fl_rsp got v=%b d=%h want 1 10000030", b3.f_rvalid, b3.f_rdata); end
      end
    end
    drain();
  endtask

  task automatic test_flush_coincident();
    // Flush with nothing outstanding must leave drop untouched.
    tick();
    b3.flush = 1'b1;
    tick();
    b3.flush = 1'b0;
    @(negedge clk);
    total++; if (d3.drop !== 1'b0) begin bad++; $display("FAIL fc_idle got %b want 0", d3.drop); end
    for (int c = 0; c < 11; c++) begin
      tick();
      b3.f_req  = (c < 7);
      b3.f_addr = (c == 0) ? 32'h24 : 32'h28;
      b3.flush  = (c == 0 || c == 6);
      @(negedge clk);
      if (c == 0) begin
        total++; if (b3.f_gnt !== 1'b1) begin bad++; $display("FAIL fc_gnt got %b want 1", b3.f_gnt); end
      end
      if (c == 1 || c == 7) begin
        total++; if (d3.drop !== 1'b1) begin bad++; $display("FAIL fc_drop_set[%0d] got %b want 1", c, d3.drop); end
      end
      if (c == 3 || c == 6 || c == 9) begin
        total++; if (b3.f_rvalid !== 1'b0 || b3.f_rdata !== 32'd0) begin bad++; $display("FAIL fc_sup[%0d] got v=%b d=%h want 0", c, b3.f_rvalid, b3.f_rdata); end
      end
      if (c == 4 || c == 10) begin
        total++; if (d3.drop !== 1'b0) begin bad++; $display("FAIL fc_drop_clr[%0d] got %b want 0", c, d3.drop); end
      end
    end
    drain();
  endtask

  task automatic test_reset_mid_access();
    tick();
    b3.l_req = 1'b1; b3.l_we = 1'b0; b3.l_addr = 32'h44; b3.f_req = 1'b1; b3.f_addr = 32'h48;
    @(negedge clk);
    total++; if (b3.l_gnt !== 1'b1) begin bad++; $display("FAIL mr_gnt got %b want 1", b3.l_gnt); end
    tick();
    rst = 1'b0;
    #1;
    total++; if (b3.m_en !== 1'b0 || b3.l_gnt !== 1'b0 || b3.f_gnt !== 1'b0 || b3.stall_f !== 1'b0) begin bad++; $display("FAIL mr_ctl got en=%b lg=%b fg=%b s=%b want 0", b3.m_en, b3.l_gnt, b3.f_gnt, b3.stall_f); end
    total++; if (b3.m_addr !== 32'd0 || b3.l_rvalid !== 1'b0 || b3.l_rdata !== 32'd0 || b3.f_rvalid !== 1'b0) begin bad++; $display("FAIL mr_bus got a=%h lv=%b ld=%h fv=%b want 0", b3.m_addr, b3.l_rvalid, b3.l_rdata, b3.f_rvalid); end
    b3.l_req = 1'b0; b3.f_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      if (c == 0) begin
        total++; if (d3.state !== 1'b0) begin bad++; $display("FAIL mr_idle got %b want 0", d3.state); end
      end
      total++; if (b3.l_rvalid !== 1'b0) begin bad++; $display("FAIL mr_no_rsp[%0d] got %b want 0", c, b3.l_rvalid); end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0;
    b1.f_req = 1'b0; b1.f_addr = '0; b1.flush = 1'b0;
    b1.l_req = 1'b0; b1.l_we = 1'b0; b1.l_addr = '0; b1.l_wdata = '0;
    b3.f_req = 1'b0; b3.f_addr = '0; b3.flush = 1'b0;
    b3.l_req = 1'b0; b3.l_we = 1'b0; b3.l_addr = '0; b3.l_wdata = '0;
    test_reset();
    test_fetch_seq();
    test_write_then_fetch();
    test_starvation();
    test_flush_drop();
    test_flush_coincident();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
